// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifetch_unit: credit-limited fetch, 2-entry response FIFO, branch kill.   |
// | IFETCH_BYPASS_EN: response bypass when FIFO empty.  Rev 1.0              |
// +--------------------------------------------------------------------------+
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm
);

  logic        run_q;
  logic [31:0] pc_q, pc_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [1:0]  out_q, out_d, kill_q, kill_d, cnt_q, cnt_d;
  logic [31:0] aq_q [2];
  logic [31:0] aq_d [2];
  logic [31:0] fi_q [2];
  logic [31:0] fi_d [2];
  logic [31:0] fp_q [2];
  logic [31:0] fp_d [2];

  logic        grant, rsp, rsp_kill, rsp_good, bypass, pop, fifo_pop, push;
  logic [2:0]  used;
  logic [1:0]  abase, fbase;
  logic [31:0] target;

  assign grant    = imem_req && imem_gnt;
  assign rsp      = imem_rvalid && (out_q != 2'd0);
  assign rsp_kill = rsp && (kill_q != 2'd0);
  assign rsp_good = rsp && !rsp_kill && !br_taken;
  assign target   = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};

`ifdef IFETCH_BYPASS_EN
  assign bypass = rsp_good && (cnt_q == 2'd0);
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = (cnt_q != 2'd0) || bypass;
  assign instr       = bypass ? imem_rdata : fi_q[0];
  assign instr_pc    = bypass ? aq_q[0] : fp_q[0];
  assign pop         = instr_valid && instr_ready;
  assign fifo_pop    = pop && (cnt_q != 2'd0);
  assign push        = rsp_good && !(bypass && instr_ready);

  // A pop this cycle frees its credit immediately, so streaming needs no bubble.
  assign used      = {1'b0, out_q} + {1'b0, cnt_q} - {2'b00, pop};
  assign imem_req  = run_q && (used < 3'd2);
  assign imem_addr = pc_q;

  always_comb begin
    pc_d       = pc_q;
    redir_d    = redir_q;
    redir_pc_d = redir_pc_q;
    if (br_taken) begin
      if (imem_req && !imem_gnt) begin
        redir_d    = 1'b1;
        redir_pc_d = target;
      end else begin
        pc_d    = target;
        redir_d = 1'b0;
      end
    end else if (grant) begin
      if (redir_q) begin
        pc_d    = redir_pc_q;
        redir_d = 1'b0;
      end else begin
        pc_d = pc_q + 32'd4;
      end
    end
  end

  // Outstanding-address queue: head is the address of the next response.
  always_comb begin
    aq_d  = aq_q;
    abase = out_q - {1'b0, rsp};
    if (rsp) aq_d[0] = aq_q[1];
    if (grant) aq_d[abase[0]] = pc_q;
    out_d = abase + {1'b0, grant};
    if (br_taken) kill_d = out_d;
    else kill_d = kill_q - {1'b0, rsp_kill} + {1'b0, grant && redir_q};
  end

  always_comb begin
    fi_d  = fi_q;
    fp_d  = fp_q;
    fbase = cnt_q - {1'b0, fifo_pop};
    cnt_d = 2'd0;
    if (!br_taken) begin
      if (fifo_pop) begin
        fi_d[0] = fi_q[1];
        fp_d[0] = fp_q[1];
      end
      if (push) begin
        fi_d[fbase[0]] = imem_rdata;
        fp_d[fbase[0]] = aq_q[0];
      end
      cnt_d = fbase + {1'b0, push};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pc_q       <= RESET_PC;
      redir_q    <= 1'b0;
      redir_pc_q <= 32'd0;
      out_q      <= 2'd0;
      kill_q     <= 2'd0;
      cnt_q      <= 2'd0;
      aq_q[0]    <= 32'd0;
      aq_q[1]    <= 32'd0;
      fi_q[0]    <= 32'd0;
      fi_q[1]    <= 32'd0;
      fp_q[0]    <= 32'd0;
      fp_q[1]    <= 32'd0;
    end else begin
      run_q      <= 1'b1;
      pc_q       <= pc_d;
      redir_q    <= redir_d;
      redir_pc_q <= redir_pc_d;
      out_q      <= out_d;
      kill_q     <= kill_d;
      cnt_q      <= cnt_d;
      aq_q[0]    <= aq_d[0];
      aq_q[1]    <= aq_d[1];
      fi_q[0]    <= fi_d[0];
      fi_q[1]    <= fi_d[1];
      fp_q[0]    <= fp_d[0];
      fp_q[1]    <= fp_d[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifetch_unit: directed stimulus with grant-time scoreboard.  Rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_ifetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] MAGIC  = 32'h5A5A_C3C3;

  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_gnt, imem_rvalid;
  logic        instr_valid, instr_ready, br_taken;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, br_pc;
  logic [15:0] br_imm;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] rq [$];
  logic [31:0] m_pc, pend_tgt, br_tgt, mon_e, held;
  logic        pend, model_g, rsp_hold, inject_rv;
  int          gcount, g0;
  bit          ok;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int n, output bit found);
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
  endtask

  // Monitor: every accepted instruction must be the oldest expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: got pc %h, expected none", instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("mon_pc", instr_pc, mon_e);
          chk("mon_instr", instr, mon_e ^ MAGIC);
        end
      end
    end
  end

  // Memory responder and expected-stream model; responses return one cycle after grant.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    m_pc   = RST_PC;
    pend   = 1'b0;
    gcount = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n !== 1'b1) begin
        m_pc = RST_PC;
        pend = 1'b0;
        exp_q.delete();
        rq.delete();
      end else begin
        model_g = imem_req && imem_gnt;
        if (model_g) begin
          gcount++;
          chk("req_addr", imem_addr, m_pc);
          rq.push_back(imem_addr);
        end
        if (br_taken) begin
          exp_q.delete();
          if (imem_req && !imem_gnt) begin
            pend     = 1'b1;
            pend_tgt = br_tgt;
          end else begin
            m_pc = br_tgt;
            pend = 1'b0;
          end
        end else if (model_g) begin
          if (pend) begin
            m_pc = pend_tgt;
            pend = 1'b0;
          end else begin
            exp_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
          end
        end
      end
      @(posedge clk);
      #2;
      if (!rsp_hold && rq.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rq.pop_front() ^ MAGIC;
      end else begin
        imem_rvalid = inject_rv;
        imem_rdata  = 32'hBAD0_0BAD;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b0; instr_ready = 1'b0; br_taken = 1'b0;
    br_pc = 32'd0; br_imm = 16'd0; br_tgt = 32'd0; rsp_hold = 1'b0; inject_rv = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_reset_outputs();

    // Reset release and back-to-back streaming
    tick(); imem_gnt = 1'b1; instr_ready = 1'b1; rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RST_PC);
    wait_valid(20, ok);
    chk("stream_start", ok, 1);
    for (int k = 0; k < 4; k++) begin
      chk("seq_valid", instr_valid, 1);
      chk("seq_pc", instr_pc, RST_PC + 32'(4 * k));
      @(negedge clk);
    end

    // Decode stall for 5 cycles
    tick(); instr_ready = 1'b0; g0 = gcount;
    @(negedge clk);
    held = instr;
    chk("stall_valid", instr_valid, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stall_instr_stable", instr, held);
    end
    #2;
    chk("stall_req_low", imem_req, 0);
    chk("stall_grants_le2", 32'(gcount - g0 <= 2), 1);
    tick(); instr_ready = 1'b1;
    repeat (6) tick();

    // Branch with two responses outstanding
    rsp_hold = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("hold_req_low", imem_req, 0);
    chk("hold_fifo_empty", instr_valid, 0);
    tick(); br_taken = 1'b1; br_pc = 32'h0040_0010; br_imm = 16'hFFFC; br_tgt = 32'h0040_0004;
    tick(); br_taken = 1'b0; rsp_hold = 1'b0;
    wait_valid(20, ok);
    chk("br_found", ok, 1);
    chk("br_first_pc", instr_pc, 32'h0040_0004);

    // Branch coincident with an accepted instruction and an arriving response
    repeat (4) tick();
    br_taken = 1'b1; br_pc = 32'h0040_0100; br_imm = 16'h0010; br_tgt = 32'h0040_0144;
    @(negedge clk);
    chk("br_ready_valid_before", instr_valid, 1);
    tick(); br_taken = 1'b0;
    @(negedge clk);
    chk("br_ready_valid_after", instr_valid, 0);
    wait_valid(20, ok);
    chk("br2_found", ok, 1);
    chk("br2_first_pc", instr_pc, 32'h0040_0144);

    // Ungranted request held across a branch
    repeat (3) tick();
    imem_gnt = 1'b0;
    @(negedge clk);
    held = imem_addr;
    chk("nogrant_req", imem_req, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("nogrant_req", imem_req, 1);
      chk("nogrant_addr_stable", imem_addr, held);
    end
    tick(); br_taken = 1'b1; br_pc = 32'h0040_0200; br_imm = 16'h0002; br_tgt = 32'h0040_020C;
    @(negedge clk);
    chk("br_nogrant_addr", imem_addr, held);
    tick(); br_taken = 1'b0; imem_gnt = 1'b1;
    @(negedge clk);
    chk("grant_old_addr", imem_addr, held);
    chk("grant_old_req", imem_req, 1);
    tick();
    @(negedge clk);
    chk("redir_addr", imem_addr, 32'h0040_020C);
    wait_valid(20, ok);
    chk("br3_found", ok, 1);
    chk("br3_first_pc", instr_pc, 32'h0040_020C);

    // Address wrap at the top of memory
    tick(); br_taken = 1'b1; br_pc = 32'hFFFF_FFF0; br_imm = 16'h0002; br_tgt = 32'hFFFF_FFFC;
    tick(); br_taken = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && imem_addr == 32'hFFFF_FFFC) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wrap_top_req", ok, 1);
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset with two responses outstanding, then a stray response
    repeat (3) tick();
    rsp_hold = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("pre_reset_req_low", imem_req, 0);
    tick(); rst_n = 1'b0; rsp_hold = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    tick(); rst_n = 1'b1; imem_gnt = 1'b0; inject_rv = 1'b1;
    @(negedge clk);
    chk("late_rvalid_valid0", instr_valid, 0);
    tick();
    @(negedge clk);
    chk("late_rvalid_valid1", instr_valid, 0);
    tick(); inject_rv = 1'b0;
    @(negedge clk);
    chk("late_rvalid_valid2", instr_valid, 0);
    tick(); imem_gnt = 1'b1;
    wait_valid(20, ok);
    chk("restart_found", ok, 1);
    chk("restart_pc", instr_pc, RST_PC);

    // Drain: every granted instruction must have been delivered
    tick(); imem_gnt = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 0);
    chk("drain_valid", instr_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address after reset.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port imem_req, output, 1, instruction-memory read request.
REQ-005 SHALL have port imem_addr, output, 32, word address of the request.
REQ-006 SHALL have port imem_gnt, input, 1, request accepted when imem_req && imem_gnt.
REQ-007 SHALL have port imem_rvalid, input, 1, read data valid; responses return in request order.
REQ-008 SHALL have port imem_rdata, input, 32, instruction word.
REQ-009 SHALL have port instr_valid, output, 1, instruction available to decode.
REQ-010 SHALL have port instr, output, 32, instruction word.
REQ-011 SHALL have port instr_pc, output, 32, address of instr.
REQ-012 SHALL have port instr_ready, input, 1, decode accepts when instr_valid && instr_ready.
REQ-013 SHALL have port br_taken, input, 1, redirect strobe.
REQ-014 SHALL have port br_pc, input, 32, address of the branch instruction.
REQ-015 SHALL have port br_imm, input, 16, branch offset field.

Function
REQ-016 SHALL hold an internal pc; each granted request SHALL advance pc by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0).
REQ-017 SHALL drive imem_addr = pc; imem_req and imem_addr SHALL stay stable from assertion until granted.
REQ-018 SHALL buffer responses in a 2-entry in-order FIFO carrying {instr, instr_pc}.
REQ-019 SHALL assert imem_req only when outstanding + FIFO occupancy < 2 (credit rule, max 2 outstanding); a request accepted in the current cycle's pop frees a credit that same cycle.
REQ-020 SHALL sustain one instruction per cycle when imem_gnt=1, rvalid 1 cycle after grant, instr_ready=1.
REQ-021 instr_valid SHALL equal FIFO non-empty; instr/instr_pc SHALL be stable while instr_valid && !instr_ready.
REQ-022 On br_taken: target = br_pc + 4 + (sign-extend(br_imm) << 2), 32-bit wrap; pc <= target next cycle.
REQ-023 On br_taken: FIFO flushed; all outstanding responses, including one granted the same cycle, marked kill and discarded on arrival.
REQ-024 br_taken while imem_req is high and not granted SHALL keep imem_addr until grant; that response is killed; the target is requested afterwards.
REQ-025 br_taken coincident with imem_rvalid SHALL discard that response; coincident with instr_ready, instr_valid SHALL be 0 next cycle.
REQ-026 imem_rvalid with no outstanding request SHALL be ignored.

Reset
REQ-027 While rst_n=0: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, FIFO empty, outstanding=0, kill=0.
REQ-028 Reset asserted mid-transaction SHALL drop all in-flight state; first request SHALL assert in the first clk edge after rst_n rises.

Configuration
REQ-029 Macro IFETCH_BYPASS_EN defined: when FIFO empty and a non-killed response arrives without br_taken, instr_valid/instr/instr_pc SHALL reflect it in the same cycle; if accepted it is not enqueued.
REQ-030 Macro IFETCH_BYPASS_EN undefined: responses SHALL always enqueue; instr_valid rises one cycle after imem_rvalid.

Verification
REQ-031 Reset release, RESET_PC=32'h0040_0000, gnt=1, rvalid 1 cycle later, ready=1 -> instr_pc sequence 0x0040_0000, 0x0040_0004, 0x0040_0008 at one per cycle.
REQ-032 instr_ready=0 for 5 cycles -> at most 2 grants, imem_req low, instr stable; ready=1 -> no instruction lost or duplicated.
REQ-033 br_taken with br_pc=0x0040_0010, br_imm=16'hFFFC, 2 responses outstanding -> both discarded, next instr_pc 0x0040_0004.
REQ-034 imem_gnt=0 for 3 cycles then br_taken, gnt=1 -> imem_addr unchanged until grant, that response killed, next request address = branch target.
REQ-035 pc=0xFFFF_FFFC sequential fetch -> next imem_addr 0x0000_0000.
REQ-036 rst_n low for 1 cycle with 2 outstanding -> all outputs at reset values; fetch restarts at RESET_PC; late rvalid ignored.
